// File: rtl/elastic_buffer_pkg.sv
// Shared definitions for elastic_buffer: occupancy-state encoding (same as
// the 2-entry skid buffer) and width helpers for the count and ring pointers.
package elastic_buffer_pkg;

    localparam logic [1:0] EMPTY = 2'b10;
    localparam logic [1:0] BUSY  = 2'b11;
    localparam logic [1:0] FULL  = 2'b01;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A ring of one or two entries still needs a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 3) ? 1 : $clog2(depth - 1);
    endfunction

endpackage

// File: rtl/elastic_buffer_ring.sv
// Storage behind the output register of elastic_buffer: one synchronous
// write port and an asynchronous read port; pointer handling lives in the top.
module elastic_buffer_ring #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 3,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [PTR_WIDTH-1:0]  wr_ptr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [PTR_WIDTH-1:0]  rd_ptr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_ptr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/elastic_buffer.sv
// Parametrised valid/ready elastic buffer: registered head plus a
// (DEPTH-1)-entry ring. Optional watermark outputs: ELASTIC_BUFFER_WATERMARK_EN.
module elastic_buffer
    import elastic_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4
`ifdef ELASTIC_BUFFER_WATERMARK_EN
    ,
    parameter int unsigned ALMOST_FULL  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY = 1
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
`ifdef ELASTIC_BUFFER_WATERMARK_EN
    ,
    output logic                          almost_full,
    output logic                          almost_empty
`endif
);

    localparam int unsigned   CW       = count_width(DEPTH);
    localparam int unsigned   PW       = ptr_width(DEPTH);
    localparam int unsigned   RING     = DEPTH - 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] ring_rdata;

    logic push, pop;
    logic ring_empty, load_direct, ring_we, ring_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // EMPTY/BUSY/FULL encoding makes bit 0 = valid, bit 1 = ready.
    assign out_valid = state_q[0];
    assign in_ready  = state_q[1];
    assign out_data  = out_data_q;
    assign count     = count_q;

    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign ring_empty  = (count_q <= CNT_ONE);
    assign load_direct = push && (!out_valid || (pop && ring_empty));
    assign ring_we     = push && !load_direct && !reset;
    assign ring_pop    = pop && !ring_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (push && !pop && (count_q == CNT_LAST)) begin
                    state_d = FULL;
                end else if (pop && !push && (count_q == CNT_ONE)) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wr_ptr_d   = ring_we  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = ring_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        out_data_d = out_data_q;
        if (load_direct) begin
            out_data_d = in_data;
        end else if (ring_pop) begin
            out_data_d = ring_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload is not reset, but reset still blocks any update to it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_q <= out_data_d;
        end
    end

    elastic_buffer_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (RING),
        .PTR_WIDTH  (PW)
    ) u_ring (
        .clk      (clk),
        .we_i     (ring_we),
        .wr_ptr_i (wr_ptr_q),
        .wdata_i  (in_data),
        .rd_ptr_i (rd_ptr_q),
        .rdata_o  (ring_rdata)
    );

`ifdef ELASTIC_BUFFER_WATERMARK_EN
    logic almost_full_q, almost_empty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (32'(count_d) >= ALMOST_FULL);
            almost_empty_q <= (32'(count_d) <= ALMOST_EMPTY);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_elastic_buffer.sv
// Self-checking bench for elastic_buffer at DEPTH 2/3/4 (and DEPTH 8 with
// ELASTIC_BUFFER_WATERMARK_EN) against a queue-based occupancy model.
module tb_elastic_buffer;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          out_ready;

    logic [DW-1:0] od4, od3, od2;
    logic          ov4, ov3, ov2;
    logic          ir4, ir3, ir2;
    logic [2:0]    c4;
    logic [1:0]    c3, c2;

    elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) u_eb4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
        .count(c4)
`ifdef ELASTIC_BUFFER_WATERMARK_EN
        , .almost_full(), .almost_empty()
`endif
    );

    elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(3)) u_eb3 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
        .count(c3)
`ifdef ELASTIC_BUFFER_WATERMARK_EN
        , .almost_full(), .almost_empty()
`endif
    );

    elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(2)) u_eb2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
        .count(c2)
`ifdef ELASTIC_BUFFER_WATERMARK_EN
        , .almost_full(), .almost_empty()
`endif
    );

`ifdef ELASTIC_BUFFER_WATERMARK_EN
    logic [DW-1:0] od8;
    logic          ov8, ir8, af8, ae8;
    logic [3:0]    c8;

    elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(8), .ALMOST_FULL(6)) u_eb8 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir8), .out_data(od8), .out_valid(ov8), .out_ready(out_ready),
        .count(c8), .almost_full(af8), .almost_empty(ae8)
    );
`endif

    int unsigned   sel;
    logic [DW-1:0] act_data;
    logic          act_valid, act_ready;
    int unsigned   act_count;

    always_comb begin
        act_data  = od4;
        act_valid = ov4;
        act_ready = ir4;
        act_count = 32'(c4);
        case (sel)
            3: begin act_data = od3; act_valid = ov3; act_ready = ir3; act_count = 32'(c3); end
            2: begin act_data = od2; act_valid = ov2; act_ready = ir2; act_count = 32'(c2); end
`ifdef ELASTIC_BUFFER_WATERMARK_EN
            8: begin act_data = od8; act_valid = ov8; act_ready = ir8; act_count = 32'(c8); end
`endif
            default: ;
        endcase
    end

    // Reference: the buffer is just a bounded FIFO of accepted beats.
    logic [DW-1:0] mq[$];
    int unsigned   depth;
    int            checks   = 0;
    int            failures = 0;
    int unsigned   popped;
    logic [DW-1:0] last_pop;
    bit            last_push;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        bit p, q;
        check("out_valid", 32'(act_valid), 32'(mq.size() != 0));
        check("in_ready", 32'(act_ready), 32'(mq.size() < int'(depth)));
        check("count", act_count, 32'(mq.size()));
        if (mq.size() != 0) check("out_data", 32'(act_data), 32'(mq[0]));
`ifdef ELASTIC_BUFFER_WATERMARK_EN
        if (sel == 8) begin
            check("almost_full", 32'(af8), 32'(mq.size() >= 6));
            check("almost_empty", 32'(ae8), 32'(mq.size() <= 1));
        end
`endif
        p = !reset && in_valid && (mq.size() < int'(depth));
        q = !reset && out_ready && (mq.size() != 0);
        if (reset) begin
            mq.delete();
        end else begin
            if (q) begin
                last_pop = mq.pop_front();
                popped++;
            end
            if (p) mq.push_back(in_data);
        end
        last_push = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned s, input int unsigned d);
        sel      = s;
        depth    = d;
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mq.delete();
        reset = 1'b0;
        check("rst_count", act_count, 0);
        check("rst_out_valid", 32'(act_valid), 0);
        check("rst_in_ready", 32'(act_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] nextv;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        sel       = 4;
        depth     = 4;
        popped    = 0;
        last_pop  = '0;
        @(negedge clk);

        // Streaming at full rate, DEPTH=4
        do_reset(4, 4);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 16'hA0 + 16'(i);
            cycle();
        end
        check("stream_count", act_count, 1);
        in_valid = 1'b0;
        repeat (3) cycle();

        // Fill to FULL, fifth beat must wait
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h11 * 16'(i + 1);
            cycle();
        end
        check("full_count", act_count, 4);
        check("full_in_ready", 32'(act_ready), 0);
        check("full_head", 32'(act_data), 32'h11);
        out_ready = 1'b1;
        cycle();
        check("after_pop_ready", 32'(act_ready), 1);
        cycle();
        in_valid = 1'b0;
        repeat (6) cycle();
        check("drain_last", 32'(last_pop), 32'h55);

        // Reset mid-stream drops held beats and the in-flight beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'h31 + 16'(i);
            cycle();
        end
        in_data = 16'h99;
        reset   = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_count", act_count, 0);
        check("midrst_valid", 32'(act_valid), 0);
        in_data = 16'h77;
        cycle();
        in_valid = 1'b0;
        check("post_rst_count", act_count, 1);
        check("post_rst_data", 32'(act_data), 32'h77);
        out_ready = 1'b1;
        repeat (2) cycle();

        // Random traffic, DEPTH=3, incrementing payload
        do_reset(3, 3);
        nextv  = '0;
        popped = 0;
        for (int n = 0; n < 20000 && popped < 2000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = nextv;
            cycle();
            if (last_push) nextv = nextv + 1'b1;
        end
        check("rand_beats", popped, 2000);
        check("rand_last", 32'(last_pop), 1999);

        // DEPTH=2 full, pop and accept in back-to-back cycles
        do_reset(2, 2);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        cycle();
        in_data = 16'hCAFE;
        cycle();
        check("d2_full_ready", 32'(act_ready), 0);
        check("d2_full_count", act_count, 2);
        in_data   = 16'hF00D;
        out_ready = 1'b1;
        cycle();
        check("d2_head_cafe", 32'(act_data), 32'hCAFE);
        check("d2_ready_back", 32'(act_ready), 1);
        cycle();
        check("d2_head_f00d", 32'(act_data), 32'hF00D);
        in_valid = 1'b0;
        repeat (2) cycle();

`ifdef ELASTIC_BUFFER_WATERMARK_EN
        do_reset(8, 8);
        check("wm_rst_af", 32'(af8), 0);
        check("wm_rst_ae", 32'(ae8), 1);
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 16'h80 + 16'(i);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
